// File: rtl/dio_pin_engine_pkg.sv
// dio_pin_engine_pkg: shared mode codes and config-word field layout for the DIO pin engine.
// Config word: [2:0] mode, [6:3] srcA, [10:7] srcB, [11] invert, [31:16] div.
package dio_pin_engine_pkg;
    localparam int CFG_W = 32;
    localparam logic [2:0] MODE_LOW    = 3'd0;
    localparam logic [2:0] MODE_HIGH   = 3'd1;
    localparam logic [2:0] MODE_COPY   = 3'd2;
    localparam logic [2:0] MODE_AND    = 3'd3;
    localparam logic [2:0] MODE_OR     = 3'd4;
    localparam logic [2:0] MODE_XOR    = 3'd5;
    localparam logic [2:0] MODE_CLKDIV = 3'd6;
    localparam logic [2:0] MODE_PULSE  = 3'd7;
    localparam int CFG_MODE_LSB = 0;
    localparam int CFG_MODE_W   = 3;
    localparam int CFG_SRCA_LSB = 3;
    localparam int CFG_SRCB_LSB = 7;
    localparam int CFG_SRC_W    = 4;
    localparam int CFG_INV_BIT  = 11;
    localparam int CFG_DIV_LSB  = 16;
    localparam int CFG_DIV_W    = 16;
endpackage

// File: rtl/dio_pin_engine_out_cell.sv
// dio_pin_engine_out_cell: one output pin - mode decode, source mux, divider/one-shot state, output flop.
// Ports: Clk, Reset (sync, active-high), enable, in_sync (synchronised levels),
//        in_rise (registered, warm-up-masked rising edges), cfg (config word), pin_out.
module dio_pin_engine_out_cell
    import dio_pin_engine_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int DIV_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             enable,
    input  logic [N_IN-1:0]  in_sync,
    input  logic [N_IN-1:0]  in_rise,
    input  logic [CFG_W-1:0] cfg,
    output logic             pin_out
);
    logic [15:0]      lvl, rise;
    logic [2:0]       mode;
    logic [3:0]       srca, srcb;
    logic             inv, a, b, a_rise, f;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] cnt_d, cnt_q;
    logic             tog_d, tog_q, busy_d, busy_q, pin_out_d, pin_out_q;
    logic             unused_cfg;

    assign unused_cfg = ^{cfg[15:12], cfg[31:16]};

    always_comb begin
        // Zero-extend to 16 so any 4-bit source index >= N_IN reads 0.
        lvl = '0;
        lvl[N_IN-1:0] = in_sync;
        rise = '0;
        rise[N_IN-1:0] = in_rise;
        mode = cfg[CFG_MODE_LSB +: CFG_MODE_W];
        srca = cfg[CFG_SRCA_LSB +: CFG_SRC_W];
        srcb = cfg[CFG_SRCB_LSB +: CFG_SRC_W];
        inv = cfg[CFG_INV_BIT];
        div = cfg[CFG_DIV_LSB +: DIV_W];
        a = lvl[srca];
        b = lvl[srcb];
        a_rise = rise[srca];
        cnt_d = '0;
        tog_d = 1'b0;
        busy_d = 1'b0;
        if (mode == MODE_CLKDIV) begin
            // >= so a div lowered below the running count wraps at once.
            cnt_d = (cnt_q >= div) ? '0 : cnt_q + 1'b1;
            tog_d = tog_q ^ (cnt_q >= div);
        end else if (mode == MODE_PULSE) begin
            // An edge always reloads, so a retrigger stretches the pulse.
            cnt_d = a_rise ? div : (busy_q && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
            busy_d = a_rise | (busy_q & (cnt_q != '0));
        end
        if (!enable) begin
            cnt_d = '0;
            tog_d = 1'b0;
            busy_d = 1'b0;
        end
        // Stateful modes use next-state so pin_out lines up with the state flops.
        f = (mode == MODE_LOW)    ? 1'b0 :
            (mode == MODE_HIGH)   ? 1'b1 :
            (mode == MODE_COPY)   ? a :
            (mode == MODE_AND)    ? (a & b) :
            (mode == MODE_OR)     ? (a | b) :
            (mode == MODE_XOR)    ? (a ^ b) :
            (mode == MODE_CLKDIV) ? tog_d : busy_d;
        pin_out_d = enable & (f ^ inv);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
            tog_q <= 1'b0;
            busy_q <= 1'b0;
            pin_out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tog_q <= tog_d;
            busy_q <= busy_d;
            pin_out_q <= pin_out_d;
        end
    end

    assign pin_out = pin_out_q;
endmodule

// File: rtl/dio_pin_engine.sv
// dio_pin_engine: DIO port processor - input synchroniser, edge detect and per-pin output functions.
// Ports: Clk, Reset (sync, active-high), enable (0 forces outputs/counters to 0),
//        pin_in (async pins), out_cfg (32 bits per output), pin_out (registered), in_sync (status).
module dio_pin_engine
    import dio_pin_engine_pkg::*;
#(
    parameter int N_IN        = 8,
    parameter int N_OUT       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   enable,
    input  logic [N_IN-1:0]        pin_in,
    input  logic [CFG_W*N_OUT-1:0] out_cfg,
    output logic [N_OUT-1:0]       pin_out,
    output logic [N_IN-1:0]        in_sync
);
    localparam int WU_W = $clog2(SYNC_STAGES + 2);
    localparam logic [WU_W-1:0] WU_MAX = WU_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][N_IN-1:0] sync_d, sync_q;
    logic [N_IN-1:0] prev_d, prev_q, rise_d, rise_q;
    logic [WU_W-1:0] wu_d, wu_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
        prev_d = sync_q[SYNC_STAGES-1];
        wu_d = (wu_q == WU_MAX) ? wu_q : wu_q + 1'b1;
        // Warm-up masks edges from pins already high when Reset releases.
        rise_d = (enable && wu_q == WU_MAX) ? (sync_q[SYNC_STAGES-1] & ~prev_q) : '0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_q <= '0;
            prev_q <= '0;
            rise_q <= '0;
            wu_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            wu_q <= wu_d;
        end
    end

    assign in_sync = sync_q[SYNC_STAGES-1];

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        dio_pin_engine_out_cell #(.N_IN(N_IN), .DIV_W(DIV_W)) u_cell (
            .Clk     (Clk),
            .Reset   (Reset),
            .enable  (enable),
            .in_sync (in_sync),
            .in_rise (rise_q),
            .cfg     (out_cfg[CFG_W*k +: CFG_W]),
            .pin_out (pin_out[k])
        );
    end
endmodule

// File: tb/tb_dio_pin_engine.sv
// tb_dio_pin_engine: directed self-checking bench for dio_pin_engine.
module tb_dio_pin_engine;
    localparam logic [2:0] M_LOW = 3'd0, M_COPY = 3'd2, M_AND = 3'd3, M_OR = 3'd4;
    localparam logic [2:0] M_XOR = 3'd5, M_DIV = 3'd6, M_PULSE = 3'd7;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic enable = 1'b1;
    logic [15:0] pin_in = '0;
    logic [127:0] cfg = '0;
    logic [3:0] pin_out;
    logic [15:0] in_sync;
    logic [7:0] pin_in2 = 8'hFF;
    logic [63:0] cfg2 = '0;
    logic [1:0] pin_out2;
    logic [7:0] in_sync2;
    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    dio_pin_engine #(.N_IN(16), .N_OUT(4), .SYNC_STAGES(2), .DIV_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .enable(enable), .pin_in(pin_in),
        .out_cfg(cfg), .pin_out(pin_out), .in_sync(in_sync)
    );

    dio_pin_engine #(.N_IN(8), .N_OUT(2), .SYNC_STAGES(2), .DIV_W(16)) dut2 (
        .Clk(Clk), .Reset(Reset), .enable(enable), .pin_in(pin_in2),
        .out_cfg(cfg2), .pin_out(pin_out2), .in_sync(in_sync2)
    );

    function automatic logic [31:0] mk(input logic [2:0] m, input logic [3:0] a, input logic [3:0] b,
                                       input logic inv, input logic [15:0] d);
        return {d, 4'b0, inv, b, a, m};
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_reset;
        pin_in = 16'hFFFF;
        cfg[0 +: 32] = mk(M_COPY, 4'd0, 4'd0, 1'b0, 16'd0);
        cfg[32 +: 32] = mk(M_COPY, 4'd1, 4'd0, 1'b0, 16'd0);
        cfg[64 +: 32] = mk(M_LOW, 4'd0, 4'd0, 1'b0, 16'd0);
        cfg[96 +: 32] = mk(M_PULSE, 4'd0, 4'd0, 1'b0, 16'd4);
        cfg2[0 +: 32] = mk(M_COPY, 4'd0, 4'd0, 1'b0, 16'd0);
        cfg2[32 +: 32] = mk(M_COPY, 4'd1, 4'd0, 1'b0, 16'd0);
        Reset = 1'b1;
        step(4);
        checks++;
        if (pin_out !== 4'b0) begin errors++; $display("FAIL reset_pin_out got %b exp 0000", pin_out); end
        checks++;
        if (in_sync !== 16'h0) begin errors++; $display("FAIL reset_in_sync got %h exp 0000", in_sync); end
        checks++;
        if (pin_out2 !== 2'b0) begin errors++; $display("FAIL reset_pin_out2 got %b exp 00", pin_out2); end
        Reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if (pin_out[3] !== 1'b0) begin errors++; $display("FAIL reset_no_pulse edge %0d got %b exp 0", k, pin_out[3]); end
        end
        checks++;
        if (pin_out[0] !== 1'b1) begin errors++; $display("FAIL reset_copy_after got %b exp 1", pin_out[0]); end
        checks++;
        if (in_sync !== 16'hFFFF) begin errors++; $display("FAIL reset_sync_after got %h exp ffff", in_sync); end
    endtask

    task automatic test_copy;
        cfg[0 +: 32] = mk(M_COPY, 4'd8, 4'd0, 1'b0, 16'd0);
        pin_in[8] = 1'b0;
        step(4);
        checks++;
        if (pin_out[0] !== 1'b0) begin errors++; $display("FAIL copy_idle got %b exp 0", pin_out[0]); end
        pin_in[8] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (pin_out[0] !== (k == 3)) begin errors++; $display("FAIL copy_latency edge %0d got %b exp %b", k, pin_out[0], k == 3); end
        end
        cfg[0 +: 32] = mk(M_COPY, 4'd8, 4'd0, 1'b1, 16'd0);
        step();
        checks++;
        if (pin_out[0] !== 1'b0) begin errors++; $display("FAIL copy_inv_hi got %b exp 0", pin_out[0]); end
        pin_in[8] = 1'b0;
        step(3);
        checks++;
        if (pin_out[0] !== 1'b1) begin errors++; $display("FAIL copy_inv_lo got %b exp 1", pin_out[0]); end
    endtask

    task automatic test_logic;
        logic [2:0] modes [3] = '{M_AND, M_OR, M_XOR};
        logic exp;
        for (int m = 0; m < 3; m++) begin
            cfg[32 +: 32] = mk(modes[m], 4'd10, 4'd11, 1'b0, 16'd0);
            for (int c = 0; c < 4; c++) begin
                pin_in[10] = c[1];
                pin_in[11] = c[0];
                exp = (m == 0) ? (c == 3) : (m == 1) ? (c != 0) : (c == 1 || c == 2);
                step(3);
                checks++;
                if (pin_out[1] !== exp) begin errors++; $display("FAIL logic mode %0d combo %0d got %b exp %b", modes[m], c, pin_out[1], exp); end
            end
        end
    endtask

    task automatic test_clkdiv;
        int divs [3] = '{0, 1, 3};
        logic exp;
        for (int i = 0; i < 3; i++) begin
            cfg[64 +: 32] = mk(M_LOW, 4'd0, 4'd0, 1'b0, 16'd0);
            step();
            cfg[64 +: 32] = mk(M_DIV, 4'd0, 4'd0, 1'b0, 16'(divs[i]));
            for (int j = 0; j < 4 * (divs[i] + 1); j++) begin
                step();
                exp = (((j + 1) / (divs[i] + 1)) % 2) == 1;
                checks++;
                if (pin_out[2] !== exp) begin errors++; $display("FAIL clkdiv div %0d cycle %0d got %b exp %b", divs[i], j, pin_out[2], exp); end
            end
        end
        cfg[64 +: 32] = mk(M_LOW, 4'd0, 4'd0, 1'b0, 16'd0);
        step();
        cfg[64 +: 32] = mk(M_DIV, 4'd0, 4'd0, 1'b0, 16'd3);
        step(2);
        checks++;
        if (pin_out[2] !== 1'b0) begin errors++; $display("FAIL clkdiv_pre_change got %b exp 0", pin_out[2]); end
        cfg[64 +: 32] = mk(M_DIV, 4'd0, 4'd0, 1'b0, 16'd0);
        for (int j = 0; j < 3; j++) begin
            step();
            checks++;
            if (pin_out[2] !== (j != 1)) begin errors++; $display("FAIL clkdiv_change cycle %0d got %b exp %b", j, pin_out[2], j != 1); end
        end
    endtask

    task automatic test_pulse;
        pin_in[0] = 1'b0;
        step(4);
        pin_in[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (pin_out[3] !== (k >= 4 && k <= 8)) begin errors++; $display("FAIL pulse edge %0d got %b exp %b", k, pin_out[3], k >= 4 && k <= 8); end
        end
        pin_in[0] = 1'b0;
        step(4);
        for (int k = 1; k <= 14; k++) begin
            pin_in[0] = !(k == 2 || k == 3);
            step();
            checks++;
            if (pin_out[3] !== (k >= 4 && k <= 11)) begin errors++; $display("FAIL retrigger edge %0d got %b exp %b", k, pin_out[3], k >= 4 && k <= 11); end
        end
    endtask

    task automatic test_abort;
        logic exp;
        cfg[64 +: 32] = mk(M_DIV, 4'd0, 4'd0, 1'b0, 16'd1);
        pin_in[0] = 1'b0;
        step(4);
        pin_in[0] = 1'b1;
        step(5);
        checks++;
        if (pin_out[3] !== 1'b1) begin errors++; $display("FAIL abort_pulse_on got %b exp 1", pin_out[3]); end
        Reset = 1'b1;
        step();
        checks++;
        if (pin_out !== 4'b0) begin errors++; $display("FAIL abort_reset got %b exp 0000", pin_out); end
        step(2);
        Reset = 1'b0;
        for (int j = 0; j < 8; j++) begin
            step();
            exp = (((j + 1) / 2) % 2) == 1;
            checks++;
            if (pin_out[3:2] !== {1'b0, exp}) begin errors++; $display("FAIL reset_restart cycle %0d got %b exp %b", j, pin_out[3:2], {1'b0, exp}); end
        end
        cfg[0 +: 32] = mk(M_COPY, 4'd1, 4'd0, 1'b1, 16'd0);
        pin_in[1] = 1'b0;
        pin_in[0] = 1'b0;
        step(4);
        pin_in[0] = 1'b1;
        step(5);
        checks++;
        if ({pin_out[3], pin_out[0]} !== 2'b11) begin errors++; $display("FAIL enable_pre got %b exp 11", {pin_out[3], pin_out[0]}); end
        enable = 1'b0;
        step();
        checks++;
        if (pin_out !== 4'b0) begin errors++; $display("FAIL enable_off got %b exp 0000", pin_out); end
        step(2);
        checks++;
        if (pin_out !== 4'b0) begin errors++; $display("FAIL enable_hold got %b exp 0000", pin_out); end
        enable = 1'b1;
        for (int j = 0; j < 8; j++) begin
            step();
            exp = (((j + 1) / 2) % 2) == 1;
            checks++;
            if (pin_out[3:2] !== {1'b0, exp}) begin errors++; $display("FAIL enable_restart cycle %0d got %b exp %b", j, pin_out[3:2], {1'b0, exp}); end
        end
        checks++;
        if (pin_out[0] !== 1'b1) begin errors++; $display("FAIL enable_inv_back got %b exp 1", pin_out[0]); end
    endtask

    task automatic test_src_range;
        cfg2[0 +: 32] = mk(M_COPY, 4'd12, 4'd0, 1'b1, 16'd0);
        cfg2[32 +: 32] = mk(M_AND, 4'd7, 4'd12, 1'b0, 16'd0);
        step(3);
        checks++;
        if (pin_out2 !== 2'b01) begin errors++; $display("FAIL src_range got %b exp 01", pin_out2); end
        checks++;
        if (in_sync2 !== 8'hFF) begin errors++; $display("FAIL src_range_sync got %h exp ff", in_sync2); end
    endtask

    initial begin
        test_reset();
        test_copy();
        test_logic();
        test_clkdiv();
        test_pulse();
        test_abort();
        test_src_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
